// File: rtl/csr_pkg.sv
// Shared CSR access types: op encodings, controller FSM states, read-only prefix
// and the read-modify-write helpers used by the access controller.
package csr_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SET   = 2'b10,
        OP_CLEAR = 2'b11
    } csrOp_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4
    } csrState_t;

    localparam logic [1:0] RO_PREFIX_DEFAULT = 2'b11;

    typedef struct packed {
        csrOp_t      op;
        logic [11:0] address;
        logic [31:0] data;
    } csrReq_t;

    function automatic logic [31:0] applyOp(input csrOp_t op, input logic [31:0] oldValue,
                                            input logic [31:0] data);
        logic [31:0] result;
        case (op)
            OP_WRITE: result = data;
            OP_SET:   result = oldValue | data;
            OP_CLEAR: result = oldValue & ~data;
            default:  result = oldValue;
        endcase
        return result;
    endfunction

    // A zero set/clear mask leaves the CSR unchanged, so it may skip the write cycle.
    function automatic logic writeNeeded(input csrOp_t op, input logic [31:0] data,
                                         input logic skipZeroMask);
        logic result;
        case (op)
            OP_WRITE:         result = 1'b1;
            OP_SET, OP_CLEAR: result = (data != 32'd0) || !skipZeroMask;
            default:          result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/csr_rr_arbiter.sv
// Two-way round-robin grant between core (bit 0) and debug (bit 1), combinational grant.
// Last-grant register advances only when accept is high; resets to debug so core wins the first tie.
module csr_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] request,
    input  logic       accept,
    output logic [1:0] grant
);

    logic lastGrantDbg;

    always_comb begin
        grant = request;
        if (request == 2'b11) begin
            grant = lastGrantDbg ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lastGrantDbg <= 1'b1;
        end else if (accept && (request != 2'b00)) begin
            lastGrantDbg <= grant[1];
        end
    end

endmodule

// File: rtl/csr_access_controller.sv
// Arbitrates core/debug CSR requests and runs a read-modify-write on the CSR block.
// Ack 3 cycles after grant without a write, 4 with; requests are ignored while busy.
module csr_access_controller
    import csr_pkg::*;
#(
    parameter bit         SKIP_ZERO_MASK = 1'b1,
    parameter logic [1:0] RO_PREFIX      = RO_PREFIX_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        coreRequest,
    input  logic [1:0]  coreOp,
    input  logic [11:0] coreAddress,
    input  logic [31:0] coreWriteData,
    output logic [31:0] coreReadData,
    output logic        coreAck,
    output logic        coreIllegal,

    input  logic        dbgRequest,
    input  logic [1:0]  dbgOp,
    input  logic [11:0] dbgAddress,
    input  logic [31:0] dbgWriteData,
    output logic [31:0] dbgReadData,
    output logic        dbgAck,
    output logic        dbgIllegal,

    output logic        csrReadEnable,
    output logic        csrWriteEnable,
    output logic [11:0] csrAddress,
    output logic [31:0] csrWriteData,
    input  logic [31:0] csrReadData,

    output logic        busy
);

    csrState_t   state;
    csrReq_t     pending;
    csrReq_t     incoming;
    logic        grantDbg;
    logic        illegalFlag;
    logic [31:0] oldValue;
    logic [1:0]  grant;
    logic        needWrite;
    logic        roTarget;

    csr_rr_arbiter u_arbiter (
        .clk     (clk),
        .rst     (rst),
        .request ({dbgRequest, coreRequest}),
        .accept  (state == IDLE),
        .grant   (grant)
    );

    always_comb begin
        if (grant[1]) begin
            incoming.op      = csrOp_t'(dbgOp);
            incoming.address = dbgAddress;
            incoming.data    = dbgWriteData;
        end else begin
            incoming.op      = csrOp_t'(coreOp);
            incoming.address = coreAddress;
            incoming.data    = coreWriteData;
        end
    end

    assign needWrite = writeNeeded(pending.op, pending.data, SKIP_ZERO_MASK);
    assign roTarget  = (pending.address[11:10] == RO_PREFIX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            pending        <= '0;
            grantDbg       <= 1'b0;
            illegalFlag    <= 1'b0;
            oldValue       <= '0;
            coreReadData   <= '0;
            coreAck        <= 1'b0;
            coreIllegal    <= 1'b0;
            dbgReadData    <= '0;
            dbgAck         <= 1'b0;
            dbgIllegal     <= 1'b0;
            csrReadEnable  <= 1'b0;
            csrWriteEnable <= 1'b0;
            csrAddress     <= '0;
            csrWriteData   <= '0;
            busy           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        grantDbg      <= grant[1];
                        pending       <= incoming;
                        illegalFlag   <= 1'b0;
                        csrReadEnable <= 1'b1;
                        csrAddress    <= incoming.address;
                        busy          <= 1'b1;
                        state         <= READ;
                    end
                end
                READ: begin
                    csrReadEnable <= 1'b0;
                    csrAddress    <= '0;
                    state         <= CAPTURE;
                end
                CAPTURE: begin
                    oldValue <= csrReadData;
                    if (needWrite && !roTarget) begin
                        csrWriteEnable <= 1'b1;
                        csrAddress     <= pending.address;
                        csrWriteData   <= applyOp(pending.op, csrReadData, pending.data);
                        state          <= WRITE;
                    end else begin
                        // Rejected writes to read-only CSRs still ack, flagged illegal.
                        illegalFlag  <= needWrite;
                        coreAck      <= !grantDbg;
                        coreReadData <= grantDbg ? 32'd0 : csrReadData;
                        coreIllegal  <= !grantDbg && needWrite;
                        dbgAck       <= grantDbg;
                        dbgReadData  <= grantDbg ? csrReadData : 32'd0;
                        dbgIllegal   <= grantDbg && needWrite;
                        state        <= DONE;
                    end
                end
                WRITE: begin
                    csrWriteEnable <= 1'b0;
                    csrAddress     <= '0;
                    csrWriteData   <= '0;
                    coreAck        <= !grantDbg;
                    coreReadData   <= grantDbg ? 32'd0 : oldValue;
                    coreIllegal    <= !grantDbg && illegalFlag;
                    dbgAck         <= grantDbg;
                    dbgReadData    <= grantDbg ? oldValue : 32'd0;
                    dbgIllegal     <= grantDbg && illegalFlag;
                    state          <= DONE;
                end
                DONE: begin
                    coreAck      <= 1'b0;
                    coreReadData <= '0;
                    coreIllegal  <= 1'b0;
                    dbgAck       <= 1'b0;
                    dbgReadData  <= '0;
                    dbgIllegal   <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_access_controller.sv
// Directed plus randomized transactions against a transaction-level model of the controller
// and a behavioural CSR block (0xC00 returns the running cycle count).
module tb_csr_access_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        coreRequest, dbgRequest;
    logic [1:0]  coreOp, dbgOp;
    logic [11:0] coreAddress, dbgAddress;
    logic [31:0] coreWriteData, dbgWriteData;
    logic [31:0] coreReadData, dbgReadData;
    logic        coreAck, dbgAck, coreIllegal, dbgIllegal;
    logic        csrReadEnable, csrWriteEnable;
    logic [11:0] csrAddress;
    logic [31:0] csrWriteData;
    logic [31:0] csrReadData = 32'd0;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem    [0:4095];
    logic [31:0] refMem [0:4095];
    logic [31:0] cyc = 32'd0;
    int          wrCount = 0;
    logic [11:0] lastWrAddr = 12'd0;
    logic [31:0] lastWrData = 32'd0;
    bit          refLastDbg;

    always #5 clk = ~clk;

    csr_access_controller dut (
        .clk(clk), .rst(rst),
        .coreRequest(coreRequest), .coreOp(coreOp), .coreAddress(coreAddress),
        .coreWriteData(coreWriteData), .coreReadData(coreReadData), .coreAck(coreAck),
        .coreIllegal(coreIllegal),
        .dbgRequest(dbgRequest), .dbgOp(dbgOp), .dbgAddress(dbgAddress),
        .dbgWriteData(dbgWriteData), .dbgReadData(dbgReadData), .dbgAck(dbgAck),
        .dbgIllegal(dbgIllegal),
        .csrReadEnable(csrReadEnable), .csrWriteEnable(csrWriteEnable),
        .csrAddress(csrAddress), .csrWriteData(csrWriteData), .csrReadData(csrReadData),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Behavioural CSR block: registered read data, writes land at the clock edge.
    always @(posedge clk) begin
        if (csrWriteEnable) begin
            mem[csrAddress] <= csrWriteData;
            wrCount++;
            lastWrAddr = csrAddress;
            lastWrData = csrWriteData;
        end
        if (csrReadEnable) csrReadData <= (csrAddress == 12'hC00) ? cyc : mem[csrAddress];
        cyc <= cyc + 32'd1;
    end

    always @(negedge clk) begin
        chk("rd_wr_exclusive", 32'(csrReadEnable & csrWriteEnable), 32'd0);
        if (!csrReadEnable && !csrWriteEnable) begin
            chk("idle_csr_addr", 32'(csrAddress), 32'd0);
            chk("idle_csr_wdata", csrWriteData, 32'd0);
        end
    end

    // One round: the selected requesters raise requests together; each holds until its own ack.
    task automatic runRound(input bit useC, input bit useD,
                            input logic [1:0] opC, input logic [11:0] adC, input logic [31:0] dC,
                            input logic [1:0] opD, input logic [11:0] adD, input logic [31:0] dD);
        bit pend [2];
        @(negedge clk);
        coreRequest = useC; coreOp = opC; coreAddress = adC; coreWriteData = dC;
        dbgRequest  = useD; dbgOp  = opD; dbgAddress  = adD; dbgWriteData  = dD;
        pend[0] = useC;
        pend[1] = useD;
        while (pend[0] || pend[1]) begin
            bit          who;
            bit          need, ill, wr;
            logic [1:0]  op;
            logic [11:0] ad;
            logic [31:0] d, oldv, newv;
            int          lat, wr0;
            who = (pend[0] && pend[1]) ? !refLastDbg : pend[1];
            op  = who ? opD : opC;
            ad  = who ? adD : adC;
            d   = who ? dD : dC;
            chk("idle_busy", 32'(busy), 32'd0);
            oldv = (ad == 12'hC00) ? cyc + 32'd1 : refMem[ad];
            need = (op == 2'b01) || (op[1] && d != 32'd0);
            ill  = need && (ad[11:10] == 2'b11);
            wr   = need && !ill;
            case (op)
                2'b01:   newv = d;
                2'b10:   newv = oldv | d;
                2'b11:   newv = oldv & ~d;
                default: newv = oldv;
            endcase
            if (wr) refMem[ad] = newv;
            refLastDbg = who;
            lat = wr ? 4 : 3;
            wr0 = wrCount;
            for (int n = 1; n <= lat; n++) begin
                @(negedge clk);
                if (n == 1) begin
                    chk("read_strobe", 32'(csrReadEnable), 32'd1);
                    chk("read_addr", 32'(csrAddress), 32'(ad));
                    // Grantee inputs change after grant; the running transaction must not care.
                    if (who) begin
                        dbgOp = 2'($urandom); dbgAddress = 12'($urandom); dbgWriteData = $urandom;
                    end else begin
                        coreOp = 2'($urandom); coreAddress = 12'($urandom); coreWriteData = $urandom;
                    end
                end
                if (n < lat) begin
                    chk("busy_mid", 32'(busy), 32'd1);
                    chk("core_ack_early", 32'(coreAck), 32'd0);
                    chk("dbg_ack_early", 32'(dbgAck), 32'd0);
                end
            end
            chk("busy_done", 32'(busy), 32'd1);
            chk("core_ack", 32'(coreAck), 32'(!who));
            chk("dbg_ack", 32'(dbgAck), 32'(who));
            chk("core_rdata", coreReadData, who ? 32'd0 : oldv);
            chk("dbg_rdata", dbgReadData, who ? oldv : 32'd0);
            chk("core_illegal", 32'(coreIllegal), 32'(!who && ill));
            chk("dbg_illegal", 32'(dbgIllegal), 32'(who && ill));
            chk("write_count", 32'(wrCount - wr0), 32'(wr));
            if (wr) begin
                chk("write_addr", 32'(lastWrAddr), 32'(ad));
                chk("write_data", lastWrData, newv);
            end
            if (who) dbgRequest = 1'b0;
            else     coreRequest = 1'b0;
            pend[who] = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [11:0] pool [6];
        int          wr0;
        int          sel;
        for (int i = 0; i < 4096; i++) begin
            mem[i]    = $urandom;
            refMem[i] = mem[i];
        end
        pool[0] = 12'h340; pool[1] = 12'h341; pool[2] = 12'h300;
        pool[3] = 12'h7FF; pool[4] = 12'hC01; pool[5] = 12'hC00;
        coreRequest = 0; coreOp = 0; coreAddress = 0; coreWriteData = 0;
        dbgRequest  = 0; dbgOp  = 0; dbgAddress  = 0; dbgWriteData  = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_core_ack", 32'(coreAck), 32'd0);
        chk("rst_dbg_ack", 32'(dbgAck), 32'd0);
        chk("rst_core_rdata", coreReadData, 32'd0);
        chk("rst_dbg_rdata", dbgReadData, 32'd0);
        chk("rst_illegal", 32'({coreIllegal, dbgIllegal}), 32'd0);
        chk("rst_enables", 32'({csrReadEnable, csrWriteEnable}), 32'd0);
        rst = 1'b0;
        refLastDbg = 1'b1;

        // Plain write returning the previous value.
        mem[12'h340] = 32'h12345678; refMem[12'h340] = 32'h12345678;
        runRound(1, 0, 2'b01, 12'h340, 32'hDEADBEEF, 2'b00, 12'h0, 32'h0);
        chk("write_value_340", lastWrData, 32'hDEADBEEF);

        // Set / clear / zero-mask set.
        mem[12'h341] = 32'h00000080; refMem[12'h341] = 32'h00000080;
        runRound(1, 0, 2'b10, 12'h341, 32'h00000008, 2'b00, 12'h0, 32'h0);
        chk("set_value", lastWrData, 32'h00000088);
        runRound(1, 0, 2'b11, 12'h341, 32'h00000080, 2'b00, 12'h0, 32'h0);
        chk("clear_value", lastWrData, 32'h00000008);
        runRound(1, 0, 2'b10, 12'h341, 32'h00000000, 2'b00, 12'h0, 32'h0);

        // Debug accesses to the read-only cycle counter.
        runRound(0, 1, 2'b00, 12'h0, 32'h0, 2'b01, 12'hC00, 32'h55AA55AA);
        runRound(0, 1, 2'b00, 12'h0, 32'h0, 2'b00, 12'hC00, 32'h0);

        // Two simultaneous-request rounds back to back.
        runRound(1, 1, 2'b01, 12'h300, 32'h11111111, 2'b10, 12'h301, 32'h0000F000);
        runRound(1, 1, 2'b11, 12'h300, 32'h00000011, 2'b01, 12'h301, 32'h22222222);

        // Reset during CAPTURE of a write aborts it.
        @(negedge clk);
        coreRequest = 1; coreOp = 2'b01; coreAddress = 12'h342; coreWriteData = 32'hA5A5A5A5;
        wr0 = wrCount;
        @(negedge clk);
        coreRequest = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        for (int n = 0; n < 3; n++) begin
            chk("abort_core_ack", 32'(coreAck), 32'd0);
            chk("abort_write_en", 32'(csrWriteEnable), 32'd0);
            @(negedge clk);
        end
        chk("abort_write_count", 32'(wrCount - wr0), 32'd0);
        chk("abort_mem", mem[12'h342], refMem[12'h342]);
        refLastDbg = 1'b1;
        runRound(1, 0, 2'b01, 12'h342, 32'hCAFEF00D, 2'b00, 12'h0, 32'h0);

        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 2);
            runRound(sel != 1, sel != 0,
                     2'($urandom), pool[$urandom_range(0, 5)],
                     ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                     2'($urandom), pool[$urandom_range(0, 5)],
                     ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/csr_access_controller.md
CSR_ACCESS_CONTROLLER -- requirements
Module: csr_access_controller

Interface
REQ-001 Parameter SKIP_ZERO_MASK, default 1: set/clear ops with zero mask SHALL issue no write cycle.
REQ-002 Parameter RO_PREFIX, default 2'b11: csrAddress[11:10] value marking read-only CSRs.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 coreRequest  in  1  core CSR transaction request.
REQ-006 coreOp  in  2  00 read, 01 write (RW), 10 set (RS), 11 clear (RC).
REQ-007 coreAddress  in  12  target CSR.
REQ-008 coreWriteData  in  32  write value or set/clear mask.
REQ-009 coreReadData  out  32  pre-operation CSR value, valid with coreAck.
REQ-010 coreAck  out  1  one-cycle completion pulse.
REQ-011 coreIllegal  out  1  valid with coreAck; write to read-only CSR rejected.
REQ-012 dbgRequest/dbgOp/dbgAddress/dbgWriteData/dbgReadData/dbgAck/dbgIllegal SHALL mirror the core ports exactly (debug requester).
REQ-013 csrReadEnable  out  1; csrWriteEnable  out  1; csrAddress  out  12; csrWriteData  out  32  to CSR block.
REQ-014 csrReadData  in  32  CSR block read data, valid the cycle after csrReadEnable.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 FSM states SHALL be IDLE, READ, CAPTURE, WRITE, DONE.
REQ-017 IDLE: if any request high, grant, latch op/address/data of grantee, go READ; else stay.
REQ-018 Both requests high in IDLE: grant the requester not granted last (2-way round-robin); single request always granted.
REQ-019 READ: csrReadEnable=1, csrAddress=latched address; go CAPTURE.
REQ-020 CAPTURE: latch csrReadData as oldValue; go WRITE if write needed, else DONE.
REQ-021 Write needed when op=01, or op in {10,11} and (mask!=0 or SKIP_ZERO_MASK=0).
REQ-022 New value: 01 -> data; 10 -> oldValue | data; 11 -> oldValue & ~data (32-bit bitwise).
REQ-023 Write needed and address[11:10]==RO_PREFIX: no WRITE state; illegal flag set, go DONE.
REQ-024 WRITE: csrWriteEnable=1, csrAddress held, csrWriteData=new value, exactly one cycle; go DONE.
REQ-025 DONE: grantee Ack=1, ReadData=oldValue, Illegal=flag; non-grantee outputs 0; go IDLE.
REQ-026 Latency: request high in IDLE cycle T -> Ack in T+4 with write, T+3 without.
REQ-027 Requester SHALL drop request in its Ack cycle; request high in a later IDLE cycle starts a new transaction.
REQ-028 Request changes after grant SHALL NOT affect the running transaction.
REQ-029 csrReadEnable and csrWriteEnable SHALL never be high together; csrAddress/csrWriteData SHALL be 0 when both enables are low.

Reset
REQ-030 rst SHALL force IDLE; all outputs 0; oldValue, illegal flag cleared; last-grant = debug (core wins first tie).
REQ-031 rst mid-transaction SHALL abort it: no Ack, and no csrWriteEnable in or after the reset cycle.

Structure
REQ-032 Op encodings, FSM state encoding and RO_PREFIX default SHALL live in shared package csr_pkg.
REQ-033 Round-robin grant logic SHALL be sub-module csr_rr_arbiter (2 requests, grant, last-grant register).

Verification
REQ-034 Core op=01 addr 0x340 data 0xDEADBEEF, CSR returns 0x12345678 -> one write 0xDEADBEEF to 0x340, coreAck at T+4, coreReadData=0x12345678.
REQ-035 Core op=10 mask 0x0000_0008 on old 0x0000_0080 -> write 0x0000_0088; op=11 mask 0x80 -> write 0x08; op=10 mask 0 -> no write, Ack at T+3.
REQ-036 Debug op=01 to 0xC00 -> no csrWriteEnable, dbgAck with dbgIllegal=1, dbgReadData=current cycle count; debug op=00 to 0xC00 -> dbgIllegal=0.
REQ-037 Core and debug request in same cycle twice back-to-back -> grants core, debug, core, debug; each Ack only to its grantee.
REQ-038 rst asserted in CAPTURE of an op=01 -> no csrWriteEnable, no Ack, busy=0 next cycle, new request completes normally.
